ascon_result_serializer: RTL and testbench



---
 rtl/ascon_pkg.sv | 19 +
 rtl/ascon_result_serializer_if.sv | 11 +
 rtl/ascon_result_serializer.sv | 107 ++++++++++
 tb/tb_ascon_result_serializer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared types, widths and helpers for the ASCON AEAD result path.
package ascon_pkg;

  localparam int unsigned TAG_W  = 128;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    ACK      = 2'd2,
    WAIT_LOW = 2'd3
  } ser_state_t;

  // Payload bytes for a y-bit ciphertext plus the 128-bit tag.
  function automatic int unsigned nbytes(input int unsigned y);
    return y / 8 + TAG_W / 8;
  endfunction

endpackage

// File: rtl/ascon_result_serializer_if.sv
// Byte stream valid/ready bus between the serializer and a byte transport.
interface ascon_result_serializer_if;

  logic [ascon_pkg::BYTE_W-1:0] m_data;
  logic                         m_valid;
  logic                         m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/ascon_result_serializer.sv
// Captures {ciphertext, tag} from the encryption core and streams it out MSB-first as bytes.
// Optional SER_LENGTH_HEADER_EN prepends a 16-bit big-endian payload byte count.
module ascon_result_serializer
  import ascon_pkg::*;
#(
  parameter  int unsigned y  = 40,
  localparam int unsigned CW = (y == 0) ? 1 : y
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [CW-1:0]                     cipher_text,
  input  logic [TAG_W-1:0]                  tag,
  input  logic                              encryption_ready,
  ascon_result_serializer_if.master         m,
  output logic                              enc_ack,
  output logic                              busy
);

  localparam int unsigned NB = nbytes(y);
`ifdef SER_LENGTH_HEADER_EN
  localparam int unsigned HDR_W = 16;
  localparam int unsigned FRAME = NB + 2;
`else
  localparam int unsigned HDR_W = 0;
  localparam int unsigned FRAME = NB;
`endif
  localparam int unsigned PW    = y + TAG_W;
  localparam int unsigned SW    = HDR_W + PW;
  localparam int unsigned CNT_W = $clog2(NB + 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

  ser_state_t       state, state_d;
  logic [SW-1:0]    shreg, shreg_d, load_word;
  logic [PW-1:0]    payload;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             m_valid_q, m_valid_d, enc_ack_d, busy_d;
  logic             xfer;

  // With y=0 there is no ciphertext; the 1-bit cipher_text port is unused.
  generate
    if (y == 0) begin : g_tag_only
      logic unused_cipher;
      assign unused_cipher = ^cipher_text;
      assign payload       = tag;
    end else begin : g_cipher_tag
      assign payload = {cipher_text, tag};
    end
  endgenerate

`ifdef SER_LENGTH_HEADER_EN
  assign load_word = {16'(NB), payload};
`else
  assign load_word = payload;
`endif

  assign xfer      = m_valid_q & m.m_ready;
  assign m.m_valid = m_valid_q;
  assign m.m_data  = shreg[SW-1 -: BYTE_W];

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state;
    shreg_d = shreg;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        if (encryption_ready) begin
          shreg_d = load_word;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          shreg_d = {shreg[SW-BYTE_W-1:0], BYTE_W'(0)};
          cnt_d   = cnt + CNT_W'(1);
          if (cnt == LAST) state_d = ACK;
        end
      end
      ACK:      state_d = WAIT_LOW;
      WAIT_LOW: if (!encryption_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    m_valid_d = (state_d == SEND);
    enc_ack_d = (state_d == ACK);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      m_valid_q <= 1'b0;
      enc_ack   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      shreg     <= shreg_d;
      cnt       <= cnt_d;
      m_valid_q <= m_valid_d;
      enc_ack   <= enc_ack_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_ascon_result_serializer.sv
// Self-checking bench for ascon_result_serializer: y=40 and y=0 instances against a byte-queue model.
module tb_ascon_result_serializer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [39:0]  cipher40 = '0;
  logic         cipher0 = 1'b0;
  logic [127:0] tag_in = '0;
  logic         er40 = 1'b0;
  logic         er0 = 1'b0;
  logic         m_ready_tb = 1'b0;
  logic         ack40, ack0, busy40, busy0;
  logic         sel = 1'b0;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  ascon_result_serializer_if bus40();
  ascon_result_serializer_if bus0();
  assign bus40.m_ready = m_ready_tb;
  assign bus0.m_ready  = m_ready_tb;

  ascon_result_serializer #(.y(40)) dut40 (
    .clk(clk), .rst(rst), .cipher_text(cipher40), .tag(tag_in),
    .encryption_ready(er40), .m(bus40), .enc_ack(ack40), .busy(busy40));

  ascon_result_serializer #(.y(0)) dut0 (
    .clk(clk), .rst(rst), .cipher_text(cipher0), .tag(tag_in),
    .encryption_ready(er0), .m(bus0), .enc_ack(ack0), .busy(busy0));

  wire [7:0] o_data  = sel ? bus0.m_data  : bus40.m_data;
  wire       o_valid = sel ? bus0.m_valid : bus40.m_valid;
  wire       o_ack   = sel ? ack0  : ack40;
  wire       o_busy  = sel ? busy0 : busy40;

  // Reference frame: optional length header, ciphertext bytes MSB-first, then tag bytes MSB-first.
  task automatic build_frame(input int unsigned ylen, input logic [39:0] c, input logic [127:0] t);
    int unsigned nb;
    nb = ylen / 8 + 16;
    exp_q.delete();
`ifdef SER_LENGTH_HEADER_EN
    exp_q.push_back(8'(nb >> 8));
    exp_q.push_back(8'(nb));
`endif
    for (int i = 0; i < int'(ylen / 8); i++) exp_q.push_back(8'(c >> (ylen - 8 * (i + 1))));
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(t >> (120 - 8 * i)));
  endtask

  task automatic set_er(input logic v);
    if (sel) er0 = v; else er40 = v;
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic run_frame(input string name, input logic [39:0] c, input logic [127:0] t,
                           input int mode, input int hold);
    int n, idx, cyc;
    logic stalled, rdy;
    logic [7:0] held;
    build_frame(sel ? 0 : 40, c, t);
    n = exp_q.size();
    @(negedge clk);
    cipher40 = c; tag_in = t; m_ready_tb = 1'b0;
    set_er(1'b1);
    @(negedge clk);
    tests++;
    if (o_valid !== 1'b1) begin
      fails++; $display("FAIL %s first_valid_latency: m_valid=%b want 1", name, o_valid);
    end
    idx = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (idx < n && cyc < 1000) begin
      tests++;
      if (o_valid !== 1'b1 || o_ack !== 1'b0 || o_busy !== 1'b1) begin
        fails++;
        $display("FAIL %s in_frame byte %0d: m_valid=%b enc_ack=%b busy=%b want 1 0 1",
                 name, idx, o_valid, o_ack, o_busy);
      end
      if (stalled) begin
        tests++;
        if (o_data !== held) begin
          fails++; $display("FAIL %s stall_hold byte %0d: m_data=%h want %h", name, idx, o_data, held);
        end
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      m_ready_tb = rdy;
      if (rdy) begin
        tests++;
        if (o_data !== exp_q[idx]) begin
          fails++; $display("FAIL %s data byte %0d: m_data=%h want %h", name, idx, o_data, exp_q[idx]);
        end
        idx++; stalled = 1'b0;
      end else begin
        stalled = 1'b1; held = o_data;
      end
      cipher40 = {8'($urandom), $urandom};
      tag_in   = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      cyc++;
    end
    m_ready_tb = 1'b0;
    tests++;
    if (idx != n) begin
      fails++; $display("FAIL %s byte_count: accepted=%0d want %0d", name, idx, n);
    end
    if (mode == 0) begin
      tests++;
      if (cyc != n) begin
        fails++; $display("FAIL %s back_to_back: cycles=%0d want %0d", name, cyc, n);
      end
    end
    tests++;
    if (o_valid !== 1'b0 || o_ack !== 1'b1 || o_busy !== 1'b1) begin
      fails++;
      $display("FAIL %s ack_cycle: m_valid=%b enc_ack=%b busy=%b want 0 1 1", name, o_valid, o_ack, o_busy);
    end
    for (int k = 0; k <= hold; k++) begin
      @(negedge clk);
      tests++;
      if (o_valid !== 1'b0 || o_ack !== 1'b0 || o_busy !== 1'b1) begin
        fails++;
        $display("FAIL %s wait_low cycle %0d: m_valid=%b enc_ack=%b busy=%b want 0 0 1",
                 name, k, o_valid, o_ack, o_busy);
      end
    end
    set_er(1'b0);
    @(negedge clk);
    tests++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_ack !== 1'b0) begin
      fails++;
      $display("FAIL %s back_to_idle: busy=%b m_valid=%b enc_ack=%b want 0 0 0", name, o_busy, o_valid, o_ack);
    end
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if (bus40.m_valid !== 1'b0 || ack40 !== 1'b0 || busy40 !== 1'b0 || bus40.m_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_y40: m_valid=%b enc_ack=%b busy=%b m_data=%h want 0 0 0 00",
               bus40.m_valid, ack40, busy40, bus40.m_data);
    end
    tests++;
    if (bus0.m_valid !== 1'b0 || ack0 !== 1'b0 || busy0 !== 1'b0 || bus0.m_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_y0: m_valid=%b enc_ack=%b busy=%b m_data=%h want 0 0 0 00",
               bus0.m_valid, ack0, busy0, bus0.m_data);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (bus40.m_valid !== 1'b0 || busy40 !== 1'b0 || bus0.m_valid !== 1'b0 || busy0 !== 1'b0) begin
      fails++;
      $display("FAIL idle_no_ready: m_valid=%b/%b busy=%b/%b want 0", bus40.m_valid, bus0.m_valid, busy40, busy0);
    end
  endtask

  task automatic test_directed();
    sel = 1'b0;
    run_frame("directed", 40'h0102030405, 128'h101112131415161718191A1B1C1D1E1F, 0, 2);
  endtask

  task automatic test_stall();
    sel = 1'b0;
    run_frame("stall_1001", 40'h0102030405, 128'h101112131415161718191A1B1C1D1E1F, 1, 2);
  endtask

  task automatic test_hold_ready();
    sel = 1'b0;
    run_frame("ready_held", 40'h0102030405, 128'h101112131415161718191A1B1C1D1E1F, 0, 100);
  endtask

  task automatic test_reset_mid_frame();
    sel = 1'b0;
    build_frame(40, 40'h0102030405, 128'h101112131415161718191A1B1C1D1E1F);
    @(negedge clk);
    cipher40 = 40'h0102030405; tag_in = 128'h101112131415161718191A1B1C1D1E1F;
    m_ready_tb = 1'b1; er40 = 1'b1;
    @(negedge clk);
    repeat (7) @(negedge clk);
    tests++;
    if (bus40.m_valid !== 1'b1 || bus40.m_data !== exp_q[7]) begin
      fails++;
      $display("FAIL pre_reset_byte8: m_valid=%b m_data=%h want 1 %h", bus40.m_valid, bus40.m_data, exp_q[7]);
    end
    #2 rst = 1'b0; er40 = 1'b0; m_ready_tb = 1'b0;
    #1;
    tests++;
    if (bus40.m_valid !== 1'b0 || busy40 !== 1'b0 || ack40 !== 1'b0 || bus40.m_data !== 8'h00) begin
      fails++;
      $display("FAIL async_reset: m_valid=%b busy=%b enc_ack=%b m_data=%h want 0 0 0 00",
               bus40.m_valid, busy40, ack40, bus40.m_data);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_frame("after_reset", 40'h0102030405, 128'h101112131415161718191A1B1C1D1E1F, 0, 1);
  endtask

  task automatic test_y0();
    sel = 1'b1;
    run_frame("y0_tag_only", 40'h0, {16{8'hA5}}, 0, 2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      sel = 1'(i % 2);
      run_frame($sformatf("random_%0d", i), {8'($urandom), $urandom},
                {$urandom, $urandom, $urandom, $urandom}, 2, $urandom_range(0, 5));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_hold_ready();
    test_reset_mid_frame();
    test_y0();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
